// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine (RV32).
// Turns one EX/MEM load or store into a single req/ack transaction on the data-memory port.
// Store data is replicated across byte lanes with matching byte enables. Load data is
// extracted from the returned word and sign- or zero-extended. The pipeline is stalled until
// the transaction finishes. Illegal or misaligned accesses raise misalign and never reach memory.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM pipeline register
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  // Pipeline control and load result
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign,
  // Data-memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic        legal;
  logic        accept;
  logic        kill_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  logic [2:0]  func3_q;
  logic [1:0]  off_q;
  logic [31:0] ld_data_q;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  // Decode legality: supported func3 for the access kind, and natural alignment.
  always_comb begin
    legal = 1'b0;
    case (func3)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
      3'b100:         legal = ~is_store;
      3'b101:         legal = ~is_store & ~addr[0];
      default:        legal = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) & req_valid & ~flush & legal;

  // Lane-replicate store data and form byte enables; loads read the whole word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (is_store) begin
      case (func3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {addr[1], 1'b0};
          wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = wdata;
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (mem_ack) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and kill flag; a flushed in-flight access still waits for its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StBusy && flush) begin
        kill_q <= 1'b1;
      end else if (state_q == StResp) begin
        kill_q <= 1'b0;
      end
    end
  end

  // Memory port registers: loaded on accept, held through BUSY, request dropped on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else if (accept) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= is_store;
      mem_addr_q  <= {addr[31:2], 2'b00};
      mem_be_q    <= be_d;
      mem_wdata_q <= wdata_d;
    end else if (state_q == StBusy && mem_ack) begin
      mem_req_q   <= 1'b0;
    end
  end

  // Select the addressed byte/halfword from the returned word and extend it.
  always_comb begin
    unique case (off_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h0, rd_byte};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Load bookkeeping: width/offset captured on accept, result registered on a live ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      func3_q   <= 3'b000;
      off_q     <= 2'b00;
      ld_data_q <= 32'h0;
    end else begin
      if (accept) begin
        func3_q <= func3;
        off_q   <= addr[1:0];
      end
      if (state_q == StBusy && mem_ack && !mem_we_q && !kill_q && !flush) begin
        ld_data_q <= ld_ext;
      end
    end
  end

  // Pipeline-facing outputs; stall and misalign are forced low during reset.
  always_comb begin
    stall    = ~rst & (accept | (state_q == StBusy));
    misalign = ~rst & (state_q == StIdle) & req_valid & ~flush & ~legal;
    ld_valid = ~rst & (state_q == StResp) & ~mem_we_q & ~kill_q & ~flush;
  end

  assign ld_data   = ld_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: randomized and directed accesses against a timeline model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .is_store  (is_store),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .flush     (flush),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle
  bit        chk_en = 1'b0;
  bit        exp_stall, exp_mis, exp_req, exp_we, exp_ldv, exp_full;
  bit [31:0] exp_addr, exp_wdata;
  bit [3:0]  exp_be;
  bit [31:0] ld_model;
  bit        ld_chk;

  // Snapshots of DUT outputs for literal checks
  int        snap_stall_cnt;
  int        snap_req_cnt;
  bit [31:0] snap_addr, snap_wdata, snap_ld;
  bit [3:0]  snap_be;
  bit        snap_we, snap_ldv, snap_mis;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int size;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (st && f3[2]) return 1'b0;
    size = m_size(f3);
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic bit [3:0] m_be(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int m;
    if (!st) return 4'hF;
    m = ((1 << m_size(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic bit [31:0] m_wdata(input bit st, input bit [2:0] f3, input bit [31:0] w);
    longint lo, r, rep;
    int size;
    if (!st) return w;
    size = m_size(f3);
    lo  = longint'(w) % (longint'(1) << (8 * size));
    rep = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'h1;
    r   = lo * rep;
    return r[31:0];
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] rd);
    longint v, lim;
    int size;
    size = m_size(f3);
    lim  = longint'(1) << (8 * size);
    v    = (longint'(rd) >> (8 * int'(off))) % lim;
    if (!f3[2] && size < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("misalign", 32'(misalign), 32'(exp_mis));
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("ld_valid", 32'(ld_valid), 32'(exp_ldv));
      if (exp_req || exp_full) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", 32'(mem_be), 32'(exp_be));
        check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (ld_chk) check("ld_data", ld_data, ld_model);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_quiet();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_ldv = 1'b0; exp_full = 1'b0;
  endtask

  task automatic sample_snap();
    @(negedge clk);
    snap_stall_cnt += int'(stall);
    snap_req_cnt   += int'(mem_req);
  endtask

  // One complete access as seen from the MEM stage.
  task automatic access(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input bit [31:0] rd, input int nack, input int fl_busy, input bit fl_resp);
    bit lg, killed;
    lg = m_legal(st, f3, a);
    killed = 1'b0;
    snap_stall_cnt = 0;
    snap_req_cnt = 0;
    // accept / reject cycle
    tick();
    req_valid = 1'b1; is_store = st; func3 = f3; addr = a; wdata = wd; flush = 1'b0;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    exp_quiet();
    exp_stall = lg;
    exp_mis   = ~lg;
    sample_snap();
    snap_mis = misalign;
    if (!lg) return;
    // busy cycles
    for (int k = 1; k <= nack; k++) begin
      tick();
      mem_ack   = (k == nack);
      mem_rdata = (k == nack) ? rd : $urandom;
      flush     = (k == fl_busy);
      if (k == fl_busy) killed = 1'b1;
      exp_quiet();
      exp_stall = 1'b1;
      exp_req   = 1'b1;
      exp_we    = st;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_be    = m_be(st, f3, a);
      exp_wdata = m_wdata(st, f3, wd);
      sample_snap();
      snap_addr = mem_addr; snap_be = mem_be; snap_wdata = mem_wdata; snap_we = mem_we;
    end
    // response cycle
    tick();
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    flush     = fl_resp;
    exp_quiet();
    exp_ldv = ~st & ~killed & ~fl_resp;
    if (!st) begin
      if (killed) begin
        ld_chk = 1'b0;
      end else begin
        ld_model = m_load(f3, a[1:0], rd);
        ld_chk = 1'b1;
      end
    end
    sample_snap();
    snap_ldv = ld_valid;
    snap_ld  = ld_data;
  endtask

  // A cycle with nothing for the unit to do (absent or flushed instruction).
  task automatic idle_cycle();
    tick();
    req_valid = 1'($urandom % 2);
    flush     = req_valid;
    is_store  = 1'($urandom % 2);
    func3     = 3'($urandom % 8);
    addr      = $urandom;
    wdata     = $urandom;
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    exp_quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit        st;
    bit [2:0]  f3;
    bit [31:0] a;
    int        nack, flb, t;
    bit        flr;

    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; func3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset values
    tick();
    exp_quiet();
    exp_full = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    ld_model = 32'h0; ld_chk = 1'b1;
    chk_en = 1'b1;
    tick();
    req_valid = 1'b1;  // still held in reset: no stall allowed
    tick();
    rst = 1'b0; req_valid = 1'b0;
    exp_quiet();

    // SW then LW of the same word, zero-wait
    access(1'b1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 1, -1, 1'b0);
    check("sw_stall_cycles", snap_stall_cnt, 2);
    check("sw_req_cycles", snap_req_cnt, 1);
    check("sw_we", 32'(snap_we), 32'd1);
    check("sw_addr", snap_addr, 32'h100);
    check("sw_be", 32'(snap_be), 32'hF);
    check("sw_ldv", 32'(snap_ldv), 32'd0);
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 1, -1, 1'b0);
    check("lw_ldv", 32'(snap_ldv), 32'd1);
    check("lw_data", snap_ld, 32'h1234_5678);

    // Byte/halfword extraction
    access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80AA_BBCC, 1, -1, 1'b0);
    check("lb_data", snap_ld, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80AA_BBCC, 2, -1, 1'b0);
    check("lbu_data", snap_ld, 32'h0000_0080);
    access(1'b0, 3'b101, 32'h202, 32'h0, 32'h80AA_BBCC, 1, -1, 1'b0);
    check("lhu_data", snap_ld, 32'h0000_80AA);

    // Upper-half store
    access(1'b1, 3'b001, 32'h302, 32'h0000_BEEF, 32'h0, 1, -1, 1'b0);
    check("sh_be", 32'(snap_be), 32'hC);
    check("sh_wdata", snap_wdata, 32'hBEEF_BEEF);
    check("sh_addr", snap_addr, 32'h300);

    // Slow memory
    access(1'b0, 3'b010, 32'h1000, 32'h0, 32'hCAFE_F00D, 5, -1, 1'b0);
    check("slow_stall_cycles", snap_stall_cnt, 6);
    check("slow_req_cycles", snap_req_cnt, 5);
    check("slow_ldv", 32'(snap_ldv), 32'd1);

    // Illegal accesses
    access(1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 1, -1, 1'b0);
    check("mis_lw", 32'(snap_mis), 32'd1);
    check("mis_lw_stall", snap_stall_cnt, 0);
    access(1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1, -1, 1'b0);
    check("mis_f3", 32'(snap_mis), 32'd1);
    access(1'b1, 3'b100, 32'h1000, 32'h0, 32'h0, 1, -1, 1'b0);
    check("mis_st_f3", 32'(snap_mis), 32'd1);
    idle_cycle();

    // Flush during BUSY: bus still runs to ack, no load result
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, 3, 1, 1'b0);
    check("flush_req_cycles", snap_req_cnt, 3);
    check("flush_ldv", 32'(snap_ldv), 32'd0);
    // Flush in RESP
    access(1'b0, 3'b010, 32'h404, 32'h0, 32'h7777_1111, 1, -1, 1'b1);
    check("flush_resp_ldv", 32'(snap_ldv), 32'd0);

    // Reset while BUSY
    tick();
    req_valid = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h500; flush = 1'b0;
    mem_ack = 1'b0;
    exp_quiet(); exp_stall = 1'b1;
    tick();
    exp_quiet(); exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
    exp_addr = 32'h500; exp_be = 4'hF; exp_wdata = 32'h0;
    tick();
    rst = 1'b1;
    exp_quiet(); exp_req = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    exp_quiet();
    exp_full = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    ld_model = 32'h0; ld_chk = 1'b1;
    idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom % 2);
      if ($urandom % 8 == 0) begin
        f3 = 3'($urandom % 8);
      end else if (st) begin
        f3 = 3'($urandom % 3);
      end else begin
        t  = int'($urandom % 5);
        f3 = (t < 3) ? 3'(t) : 3'(t + 1);
      end
      a = $urandom;
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      nack = ($urandom % 6 == 0) ? 5 + int'($urandom % 3) : 1 + int'($urandom % 3);
      flb  = ($urandom % 6 == 0) ? 1 + int'($urandom % nack) : -1;
      flr  = ($urandom % 7 == 0);
      access(st, f3, a, $urandom, $urandom, nack, flb, flr);
      t = int'($urandom % 3);
      for (int j = 0; j < t; j++) idle_cycle();
      if (!m_legal(st, f3, a) && t == 0) idle_cycle();
    end

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
